cim_layer_ctrl: RTL and testbench

- Layer sequencer that time-shares one 8-input compute-in-memory neuron datapath across up to NUM_NEURONS output neurons.
- Per neuron: captures one activation vector for the whole layer, fetches that neuron's ternary weight row from weight memory, issues the neuron, waits for its result and writes the result to a result buffer.
- Sits between the layer-level control and the neuron MAC, which has a start/valid handshake.

---
 rtl/cim_layer_ctrl.sv | 144 ++++++++++++++
 tb/tb_cim_layer_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_layer_ctrl.sv
// Layer sequencer: runs up to NUM_NEURONS neurons through one shared 8-input
// CIM neuron, one at a time, and writes each result to the result buffer.
module cim_layer_ctrl #(
  parameter int NUM_NEURONS = 4,
  parameter int ACT_W       = 9,
  parameter int WGT_W       = 2,
  parameter int OUT_W       = 12,
  parameter int NEU_TIMEOUT = 16,
  parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [IDX_W:0]       cfg_count,
  input  logic [8*ACT_W-1:0]   act_in,
  output logic [IDX_W-1:0]     wmem_addr,
  input  logic [8*WGT_W-1:0]   wmem_rdata,
  output logic [8*ACT_W-1:0]   neu_act,
  output logic [8*WGT_W-1:0]   neu_wgt,
  output logic                 neu_start,
  input  logic                 neu_valid,
  input  logic [OUT_W-1:0]     neu_result,
  output logic                 res_wr_en,
  output logic [IDX_W-1:0]     res_wr_addr,
  output logic [OUT_W-1:0]     res_wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err
);

  localparam int TO_W = (NEU_TIMEOUT > 2) ? $clog2(NEU_TIMEOUT) : 1;
  localparam logic [IDX_W:0]  MAX_CNT = (IDX_W+1)'(NUM_NEURONS);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(NEU_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W:0]      cnt_q;
  logic [TO_W-1:0]     to_q;
  logic [8*ACT_W-1:0]  act_q;
  logic [8*WGT_W-1:0]  wgt_q;
  logic [OUT_W-1:0]    res_q;
  logic                neu_start_q;
  logic                wr_en_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  // Pulse outputs default low each cycle and are raised on entry to their state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      to_q        <= '0;
      act_q       <= '0;
      wgt_q       <= '0;
      res_q       <= '0;
      neu_start_q <= 1'b0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      neu_start_q <= 1'b0;
      wr_en_q     <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            act_q  <= act_in;
            cnt_q  <= (cfg_count > MAX_CNT) ? MAX_CNT : cfg_count;
            idx_q  <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            if (cfg_count == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          wgt_q       <= wmem_rdata;
          neu_start_q <= 1'b1;
          state_q     <= S_ISSUE;
        end
        S_ISSUE: begin
          to_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving in the last allowed cycle still beats the timeout.
          if (neu_valid) begin
            res_q   <= neu_result;
            wr_en_q <= 1'b1;
            state_q <= S_WRITE;
          end else if (to_q == TO_LAST) begin
            res_q   <= '0;
            err_q   <= 1'b1;
            wr_en_q <= 1'b1;
            state_q <= S_WRITE;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        S_WRITE: begin
          if ({1'b0, idx_q} == cnt_q - (IDX_W+1)'(1)) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign wmem_addr   = idx_q;
  assign neu_act     = act_q;
  assign neu_wgt     = wgt_q;
  assign neu_start   = neu_start_q;
  assign res_wr_en   = wr_en_q;
  assign res_wr_addr = idx_q;
  assign res_wr_data = res_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_cim_layer_ctrl.sv
// Directed bench for cim_layer_ctrl: weight memory and neuron models, write
// scoreboard keyed on cycle/address/data, and per-layer timing checks.
module tb_cim_layer_ctrl;

  localparam int NN    = 4;
  localparam int ACT_W = 9;
  localparam int WGT_W = 2;
  localparam int OUT_W = 12;
  localparam int TO    = 16;
  localparam int IDX_W = 2;
  localparam int W     = 16 + IDX_W + OUT_W;

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic [IDX_W:0]       cfg_count;
  logic [8*ACT_W-1:0]   act_in;
  logic [IDX_W-1:0]     wmem_addr;
  logic [8*WGT_W-1:0]   wmem_rdata;
  logic [8*ACT_W-1:0]   neu_act;
  logic [8*WGT_W-1:0]   neu_wgt;
  logic                 neu_start;
  logic                 neu_valid;
  logic [OUT_W-1:0]     neu_result;
  logic                 res_wr_en;
  logic [IDX_W-1:0]     res_wr_addr;
  logic [OUT_W-1:0]     res_wr_data;
  logic                 busy;
  logic                 done;
  logic                 timeout_err;

  cim_layer_ctrl #(
    .NUM_NEURONS(NN), .ACT_W(ACT_W), .WGT_W(WGT_W), .OUT_W(OUT_W), .NEU_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_count(cfg_count), .act_in(act_in),
    .wmem_addr(wmem_addr), .wmem_rdata(wmem_rdata), .neu_act(neu_act), .neu_wgt(neu_wgt),
    .neu_start(neu_start), .neu_valid(neu_valid), .neu_result(neu_result),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int e = 0;
  always @(posedge clk) e <= e + 1;

  // weight memory: registered read, one cycle latency
  logic [8*WGT_W-1:0] wrow [NN];
  initial begin
    wrow[0] = 16'h0D37;
    wrow[1] = 16'hFFFF;
    wrow[2] = 16'h5555;
    wrow[3] = 16'h7C13;
  end
  always @(posedge clk) wmem_rdata <= wrow[wmem_addr];

  // scoreboard state
  logic [W-1:0]        exp_q[$];
  int                  total = 0;
  int                  passes = 0;
  int                  base = 0;
  int                  lat_tab [NN];
  logic [OUT_W-1:0]    res_tab [NN];
  int                  issue_idx, pend, dly;
  logic [OUT_W-1:0]    pend_res;
  int                  done_cnt, done_cyc, busy_cnt, act_bad, wr_cnt;
  logic [8*ACT_W-1:0]  act_exp;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_wr(input int c, input int a, input logic [OUT_W-1:0] d);
    exp_q.push_back({16'(c), IDX_W'(a), d});
  endtask

  // neuron model + output monitor, both on the falling edge
  always @(negedge clk) begin
    int c;
    logic [W-1:0] x;
    c = e - base;
    if (reset) begin
      pend = 0;
      neu_valid = 1'b0;
    end else begin
      neu_valid = 1'b0;
      if (pend != 0) begin
        dly--;
        if (dly == 0) begin
          neu_valid  = 1'b1;
          neu_result = pend_res;
          pend = 0;
        end
      end
      if (neu_start) begin
        chk("issue_wgt", neu_wgt, wrow[issue_idx % NN]);
        if (lat_tab[issue_idx % NN] > 0) begin
          pend     = 1;
          dly      = lat_tab[issue_idx % NN];
          pend_res = res_tab[issue_idx % NN];
        end
        issue_idx++;
      end
      if (busy) begin
        busy_cnt++;
        if (neu_act !== act_exp) act_bad++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (res_wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) chk("unexpected_write", {16'(c), res_wr_addr, res_wr_data}, 0);
        else begin
          x = exp_q.pop_front();
          chk("write", {16'(c), res_wr_addr, res_wr_data}, x);
        end
      end
    end
  end

  // driver tasks
  task automatic set_model(input int l0, input int l1, input int l2, input int l3);
    lat_tab[0] = l0; lat_tab[1] = l1; lat_tab[2] = l2; lat_tab[3] = l3;
    for (int i = 0; i < NN; i++) res_tab[i] = OUT_W'(10 * i);
  endtask

  task automatic start_layer(input logic [IDX_W:0] cnt);
    @(negedge clk);
    issue_idx = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0; act_bad = 0; wr_cnt = 0;
    base = e;
    cfg_count = cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    act_in = {$urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(input int max);
    for (int k = 0; k < max && done_cnt == 0; k++) @(negedge clk);
    chk("done_seen", done_cnt > 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic push_normal();
    for (int i = 0; i < NN; i++) push_wr(7 + 7 * i, i, OUT_W'(10 * i));
  endtask

  int lanes [8] = '{-256, 255, -1, 0, 1, 2, 3, 4};

  initial begin
    reset = 1'b1; start = 1'b0; cfg_count = '0; act_in = '0;
    neu_valid = 1'b0; neu_result = '0;
    issue_idx = 0; pend = 0; dly = 0; pend_res = '0;
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; act_bad = 0; wr_cnt = 0;
    set_model(3, 3, 3, 3);
    for (int i = 0; i < 8; i++) act_exp[i*ACT_W +: ACT_W] = ACT_W'(lanes[i]);

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_start", neu_start, 0);
    chk("rst_wr_en", res_wr_en, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_act", neu_act, 0);
    chk("rst_wgt", neu_wgt, 0);
    chk("rst_addr", wmem_addr, 0);
    chk("rst_wdata", res_wr_data, 0);
    reset = 1'b0;

    // normal layer, act_in changed afterwards, stray start while busy
    act_in = act_exp;
    push_normal();
    start_layer(4);
    repeat (8) @(negedge clk);
    cfg_count = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100);
    chk("n_done_cyc", done_cyc, 29);
    chk("n_done_cnt", done_cnt, 1);
    chk("n_busy_cnt", busy_cnt, 29);
    chk("n_act_bad", act_bad, 0);
    chk("n_err", timeout_err, 0);
    chk("n_left", exp_q.size(), 0);
    chk("n_busy_end", busy, 0);

    // idx 1 never answers
    set_model(3, 0, 3, 3);
    push_wr(7, 0, 0); push_wr(27, 1, 0); push_wr(34, 2, 20); push_wr(41, 3, 30);
    act_in = act_exp;
    start_layer(4);
    wait_done(100);
    chk("t_done_cyc", done_cyc, 42);
    chk("t_err", timeout_err, 1);
    chk("t_left", exp_q.size(), 0);

    // empty layer also clears the sticky error
    start_layer(0);
    wait_done(20);
    chk("z_done_cyc", done_cyc, 1);
    chk("z_busy_cnt", busy_cnt, 1);
    chk("z_writes", wr_cnt, 0);
    chk("z_err", timeout_err, 0);

    // result in the final WAIT cycle wins over the timeout
    set_model(16, 3, 3, 3);
    res_tab[0] = 12'hFFB;
    push_wr(20, 0, 12'hFFB);
    act_in = act_exp;
    start_layer(1);
    wait_done(60);
    chk("c_done_cyc", done_cyc, 21);
    chk("c_err", timeout_err, 0);
    chk("c_left", exp_q.size(), 0);

    // oversize count is clamped
    set_model(3, 3, 3, 3);
    push_normal();
    act_in = act_exp;
    start_layer(7);
    wait_done(100);
    chk("o_writes", wr_cnt, 4);
    chk("o_done_cyc", done_cyc, 29);
    chk("o_left", exp_q.size(), 0);

    // reset during WAIT of idx 2 aborts the layer
    push_wr(7, 0, 0); push_wr(14, 1, 10);
    act_in = act_exp;
    start_layer(4);
    repeat (18) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("a_busy", busy, 0);
    chk("a_wr_en", res_wr_en, 0);
    chk("a_start", neu_start, 0);
    chk("a_done", done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("a_done_cnt", done_cnt, 0);
    chk("a_writes", wr_cnt, 2);
    chk("a_left", exp_q.size(), 0);

    // fresh layer after abort starts from idx 0
    push_normal();
    act_in = act_exp;
    start_layer(4);
    wait_done(100);
    chk("r_done_cyc", done_cyc, 29);
    chk("r_writes", wr_cnt, 4);
    chk("r_left", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
